// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8-to-1 mux: walks enabled selects, samples Y after DWELL cycles, and emits an 8-bit word over valid/ready.
// Optional build macro MUX_SCAN_CONTINUOUS_EN restarts scans back-to-back after each acceptance.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mask,
  input  logic       y_in,
  output logic [2:0] sel,
  output logic       busy,
  output logic [7:0] sample,
  output logic       valid,
  input  logic       ready
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] sample_q, sample_d;
  logic [7:0] mask_q, mask_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] first_ch;
  logic [3:0] next_ch;

  // Lowest set bit of m at or above index from; bit 3 of the result flags "none".
  function automatic logic [3:0] find_set(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] r;
    logic       found;
    r     = 4'd8;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && m[i[2:0]] && (i >= 32'(from))) begin
        r     = 4'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      sample_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sample_d = sample_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    first_ch = find_set(mask, 4'd0);
    next_ch  = find_set(mask_q, {1'b0, sel_q} + 4'd1);

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = mask;
          sample_d = '0;
          cnt_d    = '0;
          if (!first_ch[3]) begin
            state_d = SETTLE;
            sel_d   = first_ch[2:0];
          end else begin
            state_d = DONE;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == DWELL_LAST) begin
          sample_d[sel_q] = y_in;
          cnt_d           = '0;
          if (!next_ch[3]) begin
            sel_d = next_ch[2:0];
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      DONE: begin
        if (ready) begin
`ifdef MUX_SCAN_CONTINUOUS_EN
          // Re-arm from the live mask; an empty mask stays in DONE with a zero word.
          mask_d   = mask;
          sample_d = '0;
          cnt_d    = '0;
          if (!first_ch[3]) begin
            state_d = SETTLE;
            sel_d   = first_ch[2:0];
          end
`else
          state_d = IDLE;
          sel_d   = '0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
  end

  assign sel    = sel_q;
  assign sample = sample_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a combinational mux model and a queue of expected sample words.
module tb_mux_scan_ctrl;

  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] mask;
  logic       y_in;
  logic [2:0] sel;
  logic       busy;
  logic [7:0] sample;
  logic       valid;
  logic       ready;
  logic [7:0] mux_in;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mask   (mask),
    .y_in   (y_in),
    .sel    (sel),
    .busy   (busy),
    .sample (sample),
    .valid  (valid),
    .ready  (ready)
  );

  assign y_in = mux_in[sel];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a scan in the current cycle and runs it up to the first cycle with valid.
  task automatic scan(input logic [7:0] m, input logic [7:0] din, input string tag);
    int         n;
    int         c;
    logic [2:0] ch[8];
    logic [7:0] exp_word;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      ch[i] = 3'd0;
      if (m[i]) begin
        ch[n] = 3'(i);
        n++;
      end
    end
    mux_in = din;
    mask   = m;
    start  = 1'b1;
    exp_q.push_back(m & din);
    step();
    start = 1'b0;
    mask  = 8'($urandom);
    c = 1;
    while (!valid && c <= 200) begin
      if (c <= n * DWELL) begin
        check({tag, " sel"}, sel, ch[(c - 1) / DWELL]);
        check({tag, " busy"}, busy, 1);
      end else begin
        check({tag, " overrun"}, c, n * DWELL);
      end
      step();
      c++;
    end
    check({tag, " valid cycle"}, c, n * DWELL + 1);
    check({tag, " busy at valid"}, busy, 1);
    exp_word = exp_q.pop_front();
    check({tag, " sample"}, sample, exp_word);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    mask   = 8'hFF;
    mux_in = 8'hFF;
    ready  = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step();
      check("reset sel", sel, 0);
      check("reset sample", sample, 0);
      check("reset valid", valid, 0);
      check("reset busy", busy, 0);
    end
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("idle busy", busy, 0);
    check("idle valid", valid, 0);

`ifdef MUX_SCAN_CONTINUOUS_EN
    begin
      int last_v;
      int nv;
      ready  = 1'b1;
      mux_in = 8'h3C;
      mask   = 8'h0F;
      start  = 1'b1;
      step();
      start  = 1'b0;
      last_v = 0;
      nv     = 0;
      for (int c = 1; c <= 30; c++) begin
        check("cont busy", busy, 1);
        if (valid) begin
          exp_q.push_back(8'h0C);
          check("cont sample", sample, exp_q.pop_front());
          check("cont period", c - last_v, 9);
          last_v = c;
          nv++;
        end
        step();
      end
      check("cont valid count", nv, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cont reset busy", busy, 0);
      check("cont reset valid", valid, 0);
    end
`else
    ready = 1'b1;
    scan(8'hFF, 8'b1010_0110, "full");
    step();
    check("full accept valid", valid, 0);
    check("full accept busy", busy, 0);
    check("full accept sel", sel, 0);

    scan(8'b1000_0101, 8'hFF, "sparse");
    step();
    check("sparse accept busy", busy, 0);

    ready = 1'b0;
    scan(8'h3C, 8'h5A, "bp");
    for (int i = 0; i < 10; i++) begin
      check("bp valid", valid, 1);
      check("bp sample", sample, 8'h18);
      check("bp sel", sel, 5);
      start  = ~start;
      mask   = 8'($urandom);
      mux_in = ~mux_in;
      step();
    end
    check("bp hold valid", valid, 1);
    check("bp hold sample", sample, 8'h18);
    ready = 1'b1;
    start = 1'b1;
    mask  = 8'hFF;
    step();
    check("bp accept valid", valid, 0);
    check("bp accept busy", busy, 0);
    start = 1'b0;
    step();
    check("start in accept ignored", busy, 0);

    mux_in = 8'hFF;
    mask   = 8'hFF;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid busy before rst", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst busy", busy, 0);
    check("mid rst valid", valid, 0);
    check("mid rst sel", sel, 0);
    check("mid rst sample", sample, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("no partial valid", valid, 0);
    end

    scan(8'h00, 8'hFF, "empty");
    step();
    check("empty accept busy", busy, 0);
    check("empty accept valid", valid, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that sits directly upstream of the 8-to-1 mux and consumes its output. It drives the mux select lines through every enabled channel in ascending order, holds each select for a programmable dwell time, samples the mux output `Y` and assembles the eight samples into one parallel word. The word is handed downstream with a valid/ready handshake.

## Interface
- `DWELL`, 2, cycles each select value is held before `y_in` is sampled; legal range 1..15.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request one scan; honoured only when `busy`=0.
- `mask`  input  8  channel enable, bit i enables channel Ii; latched on accepted `start`.
- `y_in`  input  1  mux output `Y`.
- `sel`  output  3  mux select; `sel[0]`→S0, `sel[1]`→S1, `sel[2]`→S2.
- `busy`  output  1  high from the cycle after accepted `start` until result accepted.
- `sample`  output  8  bit i = `y_in` sampled while `sel`=i; disabled channels read 0.
- `valid`  output  1  `sample` complete and stable.
- `ready`  input  1  downstream accepts `sample` when `valid`&&`ready`.

## Operation
- States: IDLE, SETTLE, DONE.
- IDLE: `busy`=0, `valid`=0, `sel`=0. `start`=1 latches `mask` into `mask_q`, clears `sample` to 0.
  - `mask`≠0 → SETTLE, `sel` = lowest set bit index, dwell counter = 0.
  - `mask`=0 → DONE directly, `sample`=0.
- SETTLE: dwell counter increments each cycle. On the cycle with counter = DWELL-1:
  - `sample[sel]` ← `y_in`. Counter ← 0.
  - Next higher set bit in `mask_q` exists → `sel` ← that index, stay in SETTLE.
  - Otherwise → DONE, `sel` holds last channel.
- DONE: `valid`=1, `busy`=1, `sample` and `sel` frozen. `valid`&&`ready` → IDLE (`valid`=0, `busy`=0 next cycle). `valid` never drops without acceptance.
- `start` while `busy`=1, including the acceptance cycle, is ignored. Changes on `mask` after the start cycle have no effect on the current scan.
- Channels are never revisited within a scan. Wrap-around does not occur; index 7 is the last channel.
- Reset at any time, including mid-scan or in DONE, aborts immediately: next cycle is IDLE with all outputs at reset values. No partial result is emitted.
- Reset values: `sel`=0, `sample`=0, `valid`=0, `busy`=0.

## Timing
- Cycle 0 = cycle with accepted `start`. N = popcount(`mask`).
- `busy` rises cycle 1. First select is driven in cycle 1.
- Channel k (k-th enabled, 0-based) occupies cycles 1+k·DWELL .. (k+1)·DWELL. It is sampled at the end of its last cycle.
- `valid` rises in cycle N·DWELL+1. With N=0, `valid` rises in cycle 1.
- Acceptance in cycle t → `valid`=0 and `busy`=0 in t+1. Next `start` is honoured from t+1.
- Mux is combinational. With DWELL=1, `y_in` must settle within one cycle of `sel` changing.

## Configuration
- `MUX_SCAN_CONTINUOUS_EN` defined: on acceptance in DONE, the block re-latches `mask` and goes directly to SETTLE at its lowest set bit (or stays in DONE with `sample`=0 if `mask`=0). `busy` stays 1 and `start` is not required after the first scan. Only `rst` returns the block to IDLE.
- Undefined: single-shot behaviour as in Operation. Each scan needs `start`.

## Test plan
- Reset: `rst`=1 for 2 cycles with `start`=1 → `sel`=0, `sample`=0, `valid`=0, `busy`=0 throughout. IDLE after release.
- Full scan: DWELL=2, `mask`=8'hFF, mux inputs 8'b1010_0110, `ready`=1 → `sel` steps 0..7 every 2 cycles. `valid` in cycle 17, `sample`=8'hA6, `busy`=0 in cycle 18.
- Sparse mask: `mask`=8'b1000_0101, inputs 8'hFF → `sel` visits 0,2,7 only. `valid` in cycle 7 (DWELL=2), `sample`=8'h85.
- Backpressure and ignored start: hold `ready`=0 for 10 cycles after `valid`, pulse `start` and change inputs → `valid`, `sample`, `sel` unchanged. `start` has no effect. Acceptance on `ready`=1.
- Mid-scan reset and empty mask: `rst` in cycle 5 of a full scan → IDLE next cycle, no `valid`. Then `start` with `mask`=0 → `valid` in cycle 1 with `sample`=0.
- With `MUX_SCAN_CONTINUOUS_EN` defined: one `start`, `ready`=1, `mask`=8'h0F → `valid` pulses every 9 cycles (DWELL=2) and `busy` stays 1.
